drive_sequencer: RTL
====================

Name: drive_sequencer

Overview:
- Downstream of the pattern buffer: consumes its per-phase drive/tweak fields and the pwm signal, and produces the final gate-level signals for the output drivers.
- Enforces a break-before-make dead-time on every pwm edge and applies the programmed delay to tweak legs.
- Gates each channel's tweak legs by its tweak_sense bit against the current phase.
- One instance per pattern buffer, same clock domain.

Parameters:
- buffer_width, 8, number of driver channels (matches pattern buffer field width)
- no_legs, 8, tweak legs per channel (tweak_drive_0..7)
- dead_cycles, 3, clocks with all drivers off after each pwm edge; legal range 2..15
- tweak_delay_cycles, 4, clocks into the drive phase before delayed tweak legs may assert; legal range 1..15

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pwm  input  1  phase request, same signal fed to the pattern buffer
- p_drive  input  buffer_width  p-side drive enables (active low)
- n_drive  input  buffer_width  n-side drive enables (active high)
- tweak_sense  input  buffer_width  per-channel phase in which tweak legs are allowed
- tweak_delay  input  buffer_width  per-channel: 1 = delay tweak legs by tweak_delay_cycles
- tweak_drive_0..tweak_drive_7  input  buffer_width each  tweak leg enables, leg k channel c = tweak_drive_k[c]
- gate_p  output  buffer_width  registered p gate; off = all ones
- gate_n  output  buffer_width  registered n gate; off = all zeros
- tweak_legs  output  buffer_width*no_legs  bit c*no_legs+k = leg k of channel c; off = 0
- phase  output  1  current phase (1 = high-driving)
- dead  output  1  high while in dead-time or idle

Interface rule (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, gate_p=all1, gate_n=0, tweak_legs=0, phase=0, dead=1.
  - Internal pwm_q <= pwm, so no false edge is seen after reset.
- Edge detect: edge = (pwm != pwm_q); pwm_q <= pwm every clock.
- FSM states: IDLE, DEAD, DRIVE.
  - IDLE: outputs off. On edge go to DEAD, load dcnt=dead_cycles-1, phase<=pwm.
  - DEAD: outputs off, dead=1.
    - On edge: reload dcnt=dead_cycles-1, phase<=pwm (restart dead-time).
    - Else if dcnt==0: go to DRIVE with tcnt=0.
    - Else dcnt--.
  - DRIVE: dead=0.
    - On edge: go to DEAD (reload, outputs off on that same clock edge).
    - Else tcnt increments, saturating at tweak_delay_cycles.
- DRIVE outputs, registered each clock from the current inputs (follows upstream updates):
  - phase=1: gate_p<=p_drive, gate_n<=0.
  - phase=0: gate_p<=all1, gate_n<=n_drive.
  - tweak_legs[c*no_legs+k] <= tweak_drive_k[c] & (tweak_sense[c]==phase) & (~tweak_delay[c] | tcnt>=tweak_delay_cycles).
- Latency:
  - Define cycle 0 as the clock edge at which the pwm edge is detected.
  - First driven output appears after clock dead_cycles+1.
  - Undelayed tweak legs appear together with the drive outputs.
  - Delayed legs appear tweak_delay_cycles clocks later.
- Boundary conditions:
  - pwm toggling faster than the dead-time keeps the block in DEAD; the last phase wins.
  - The outputs must never show gate_p!=all1 and gate_n!=0 on the same cycle.
  - On a DRIVE-to-DEAD transition, gate_n is forced to 0 and gate_p to all1 on the same clock edge.
- rst mid-DRIVE or mid-DEAD: all outputs off on that same clock edge, state IDLE. Leaving IDLE requires a fresh pwm edge.
- tcnt width is 4 bits. Saturation guarantees no wrap during long drive phases.

Decomposition:
- Shared package (pat_drive_pkg):
  - state encoding constants ST_IDLE/ST_DEAD/ST_DRIVE
  - P_OFF/N_OFF values
  - leg index helper constant no_legs
- Sub-module drive_timer: pwm edge detect, FSM, dcnt and tcnt. Outputs state, phase, tweak_ok.
- The top-level block holds the per-channel output registers and the leg gating.

Test Plan (defaults, buffer_width=8):
1. Reset then hold pwm=0 for 20 cycles -> gate_p=8'hFF, gate_n=0, tweak_legs=0, dead=1 throughout.
2. pwm 0->1 with p_drive=8'hA5, tweak_delay=0, tweak_sense=8'hFF, tweak_drive_3=8'h01 -> gate_p=8'hA5 and tweak_legs bit 3 set after clock 4; all off on clocks 0-3.
3. Same as 2 but tweak_delay=8'h01 -> gate_p=8'hA5 after clock 4, tweak_legs bit 3 only after clock 8.
4. In DRIVE phase=1, pwm 1->0 with n_drive=8'h3C -> gate_p=8'hFF and gate_n=0 on the edge clock, then gate_n=8'h3C after clock 4; tweak legs with tweak_sense[c]=1 stay 0.
5. Toggle pwm every 2 cycles for 10 cycles -> dead=1 and outputs off throughout; after toggling stops, drive resumes 4 clocks later with the final phase.
6. Assert rst for 1 cycle mid-DRIVE -> outputs off on the next edge, IDLE maintained until the next pwm edge. A p/n overlap checker runs in all scenarios and must never fire.

Source files
------------

// File: rtl/pat_drive_pkg.sv
// Shared constants for the drive sequencer: FSM encoding, off levels, leg count.
package pat_drive_pkg;

    // FSM state encoding, kept as plain constants for legacy tools
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DEAD  = 2'd1;
    localparam state_t ST_DRIVE = 2'd2;

    // Per-bit off levels: p gates are active low, n gates active high
    localparam logic P_OFF = 1'b1;
    localparam logic N_OFF = 1'b0;

    // Tweak legs per channel, fixed by the tweak_drive_0..7 port set
    localparam int unsigned NO_LEGS = 8;

    // Dead-time and tweak-delay counters share one width
    localparam int unsigned CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t to_cnt(input int unsigned v);
        return cnt_t'(v);
    endfunction

endpackage

// File: rtl/drive_timer.sv
// pwm edge detect plus the IDLE/DEAD/DRIVE sequencing FSM with its dead-time
// and tweak-delay counters.
module drive_timer
    import pat_drive_pkg::*;
#(
    parameter int unsigned dead_cycles        = 3,
    parameter int unsigned tweak_delay_cycles = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   pwm,
    output state_t state,
    output logic   phase,
    output logic   pwm_edge,
    output logic   tweak_ok
);

    localparam cnt_t DEAD_LOAD = to_cnt(dead_cycles - 1);
    localparam cnt_t TWK_SAT   = to_cnt(tweak_delay_cycles);

    logic   pwm_q;
    state_t state_q, state_d;
    logic   phase_q, phase_d;
    cnt_t   dcnt_q, dcnt_d;
    cnt_t   tcnt_q, tcnt_d;

    assign pwm_edge = (pwm != pwm_q);
    assign state    = state_q;
    assign phase    = phase_q;
    assign tweak_ok = (tcnt_q >= TWK_SAT);

    // Next-state: every pwm edge (re)starts the dead-time and latches the new phase
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pwm_edge) begin
                    state_d = ST_DEAD;
                    dcnt_d  = DEAD_LOAD;
                    phase_d = pwm;
                end
            end
            ST_DEAD: begin
                if (pwm_edge) begin
                    dcnt_d  = DEAD_LOAD;
                    phase_d = pwm;
                end else if (dcnt_q == '0) begin
                    state_d = ST_DRIVE;
                    tcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - 1'b1;
                end
            end
            ST_DRIVE: begin
                if (pwm_edge) begin
                    state_d = ST_DEAD;
                    dcnt_d  = DEAD_LOAD;
                    phase_d = pwm;
                end else if (tcnt_q < TWK_SAT) begin
                    // Saturate so long drive phases never wrap back below the delay
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; pwm_q tracks pwm through reset so no false edge follows it
    always_ff @(posedge clk) begin
        pwm_q <= pwm;
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

endmodule

// File: rtl/drive_sequencer.sv
// Final gate-level output stage: break-before-make gating of p/n drives and
// per-channel tweak leg gating behind the drive_timer FSM.
module drive_sequencer
    import pat_drive_pkg::*;
#(
    parameter int unsigned buffer_width       = 8,
    parameter int unsigned dead_cycles        = 3,
    parameter int unsigned tweak_delay_cycles = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pwm,
    input  logic [buffer_width-1:0]           p_drive,
    input  logic [buffer_width-1:0]           n_drive,
    input  logic [buffer_width-1:0]           tweak_sense,
    input  logic [buffer_width-1:0]           tweak_delay,
    input  logic [buffer_width-1:0]           tweak_drive_0,
    input  logic [buffer_width-1:0]           tweak_drive_1,
    input  logic [buffer_width-1:0]           tweak_drive_2,
    input  logic [buffer_width-1:0]           tweak_drive_3,
    input  logic [buffer_width-1:0]           tweak_drive_4,
    input  logic [buffer_width-1:0]           tweak_drive_5,
    input  logic [buffer_width-1:0]           tweak_drive_6,
    input  logic [buffer_width-1:0]           tweak_drive_7,
    output logic [buffer_width-1:0]           gate_p,
    output logic [buffer_width-1:0]           gate_n,
    output logic [buffer_width*NO_LEGS-1:0]   tweak_legs,
    output logic                              phase,
    output logic                              dead
);

    localparam int unsigned LEGS_W = buffer_width * NO_LEGS;

    state_t state;
    logic   cur_phase;
    logic   pwm_edge;
    logic   tweak_ok;
    logic   drive_en;

    logic [buffer_width-1:0] leg_in [NO_LEGS];

    logic [buffer_width-1:0] gate_p_q, gate_p_d;
    logic [buffer_width-1:0] gate_n_q, gate_n_d;
    logic [LEGS_W-1:0]       legs_q, legs_d;
    logic                    dead_q, dead_d;

    drive_timer #(
        .dead_cycles        (dead_cycles),
        .tweak_delay_cycles (tweak_delay_cycles)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .pwm      (pwm),
        .state    (state),
        .phase    (cur_phase),
        .pwm_edge (pwm_edge),
        .tweak_ok (tweak_ok)
    );

    // An edge in DRIVE turns everything off on that same clock edge
    assign drive_en = (state == ST_DRIVE) && !pwm_edge;

    // Collect the leg ports into an array indexed by leg number
    always_comb begin
        leg_in[0] = tweak_drive_0;
        leg_in[1] = tweak_drive_1;
        leg_in[2] = tweak_drive_2;
        leg_in[3] = tweak_drive_3;
        leg_in[4] = tweak_drive_4;
        leg_in[5] = tweak_drive_5;
        leg_in[6] = tweak_drive_6;
        leg_in[7] = tweak_drive_7;
    end

    // Output next-state: only one side of the bridge can be non-off at a time
    always_comb begin
        gate_p_d = {buffer_width{P_OFF}};
        gate_n_d = {buffer_width{N_OFF}};
        legs_d   = '0;
        dead_d   = 1'b1;
        if (drive_en) begin
            dead_d = 1'b0;
            if (cur_phase) begin
                gate_p_d = p_drive;
            end else begin
                gate_n_d = n_drive;
            end
            for (int c = 0; c < buffer_width; c++) begin
                for (int k = 0; k < NO_LEGS; k++) begin
                    legs_d[c*NO_LEGS+k] = leg_in[k][c]
                                          & (tweak_sense[c] == cur_phase)
                                          & (~tweak_delay[c] | tweak_ok);
                end
            end
        end
    end

    // Output registers, forced off synchronously by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_p_q <= {buffer_width{P_OFF}};
            gate_n_q <= {buffer_width{N_OFF}};
            legs_q   <= '0;
            dead_q   <= 1'b1;
        end else begin
            gate_p_q <= gate_p_d;
            gate_n_q <= gate_n_d;
            legs_q   <= legs_d;
            dead_q   <= dead_d;
        end
    end

    assign gate_p     = gate_p_q;
    assign gate_n     = gate_n_q;
    assign tweak_legs = legs_q;
    assign dead       = dead_q;
    assign phase      = cur_phase;

endmodule
